// File: rtl/sbox_lut_engine_if.sv
// Handshake bundle for the S-box engine: table-write port,
// vector input port, result output port and busy flag.
interface sbox_lut_engine_if #(
   parameter int NUM_LANES = 64,
   parameter int SBOX_W    = 5
);
   logic                          cfg_wr_valid_i;
   logic                          cfg_wr_ready_o;
   logic [SBOX_W-1:0]             cfg_wr_addr_i;
   logic [SBOX_W-1:0]             cfg_wr_data_i;
   logic                          in_valid_i;
   logic                          in_ready_o;
   logic                          in_bypass_i;
   logic [NUM_LANES*SBOX_W-1:0]   in_data_i;
   logic                          out_valid_o;
   logic                          out_ready_i;
   logic [NUM_LANES*SBOX_W-1:0]   out_data_o;
   logic                          busy_o;

   modport slave (
      input  cfg_wr_valid_i, cfg_wr_addr_i, cfg_wr_data_i,
      input  in_valid_i, in_bypass_i, in_data_i, out_ready_i,
      output cfg_wr_ready_o, in_ready_o, out_valid_o,
      output out_data_o, busy_o
   );

   modport master (
      output cfg_wr_valid_i, cfg_wr_addr_i, cfg_wr_data_i,
      output in_valid_i, in_bypass_i, in_data_i, out_ready_i,
      input  cfg_wr_ready_o, in_ready_o, out_valid_o,
      input  out_data_o, busy_o
   );
endinterface

// File: rtl/sbox_lut_engine.sv
// Time-multiplexed S-box engine: programmable table applied to
// LANES_PER_CYCLE lanes per beat, with a one-cycle bypass path.
module sbox_lut_engine #(
   parameter int NUM_LANES       = 64,
   parameter int SBOX_W          = 5,
   parameter int LANES_PER_CYCLE = 8
) (
   input logic              clk_i,
   input logic              rst_i,
   sbox_lut_engine_if.slave bus
);

   localparam int BEATS     = NUM_LANES / LANES_PER_CYCLE;
   localparam int BW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int ENTRIES   = 2 ** SBOX_W;
   localparam int VW        = NUM_LANES * SBOX_W;
   localparam int BEAT_BITS = LANES_PER_CYCLE * SBOX_W;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   if (NUM_LANES % LANES_PER_CYCLE != 0) begin : g_bad_cfg
      $error("LANES_PER_CYCLE must divide NUM_LANES");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [BW-1:0]         r_beat;
   logic [VW-1:0]         r_in_buf;
   logic [VW-1:0]         r_out_buf;
   logic [SBOX_W-1:0]     r_table [ENTRIES];
   logic [BEAT_BITS-1:0]  w_beat_in;
   logic [BEAT_BITS-1:0]  w_beat_out;
   logic                  w_in_ready;
   logic                  w_cfg_ready;
   logic                  w_out_valid;
   logic                  w_busy;
   logic                  w_accept;
   logic                  w_cfg_wr;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_in_ready  = 1'b0;
      w_cfg_ready = 1'b0;
      w_out_valid = 1'b0;
      w_busy      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_in_ready  = 1'b1;
            w_cfg_ready = 1'b1;
            if (bus.in_valid_i)
               w_next = bus.in_bypass_i ? S_DONE : S_BUSY;
         end
         S_BUSY: begin
            w_busy = 1'b1;
            if (r_beat == LAST_BEAT) w_next = S_DONE;
         end
         S_DONE: begin
            w_busy      = 1'b1;
            w_out_valid = 1'b1;
            if (bus.out_ready_i) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_accept = w_in_ready && bus.in_valid_i;
   assign w_cfg_wr = w_cfg_ready && bus.cfg_wr_valid_i;

   // Lanes of the current beat, each routed through the table
   always_comb begin
      w_beat_in  = r_in_buf[int'(r_beat) * BEAT_BITS +: BEAT_BITS];
      w_beat_out = '0;
      for (int j = 0; j < LANES_PER_CYCLE; j++)
         w_beat_out[j*SBOX_W +: SBOX_W] =
            r_table[w_beat_in[j*SBOX_W +: SBOX_W]];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++)
            r_table[i] <= SBOX_W'(i);
      end else if (w_cfg_wr) begin
         r_table[bus.cfg_wr_addr_i] <= bus.cfg_wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_beat    <= '0;
         r_in_buf  <= '0;
         r_out_buf <= '0;
      end else if (w_accept) begin
         r_beat   <= '0;
         r_in_buf <= bus.in_data_i;
         if (bus.in_bypass_i) r_out_buf <= bus.in_data_i;
      end else if (r_state == S_BUSY) begin
         r_beat <= r_beat + BW'(1);
         r_out_buf[int'(r_beat) * BEAT_BITS +: BEAT_BITS] <= w_beat_out;
      end
   end

   assign bus.in_ready_o     = w_in_ready;
   assign bus.cfg_wr_ready_o = w_cfg_ready;
   assign bus.out_valid_o    = w_out_valid;
   assign bus.out_data_o     = r_out_buf;
   assign bus.busy_o         = w_busy;

endmodule

// File: tb/tb_sbox_lut_engine.sv
// Scoreboard bench for sbox_lut_engine: directed vectors with
// hand-derived expected data and latency, checked by a monitor.
module tb_sbox_lut_engine;

   localparam int NL  = 64;
   localparam int W   = 5;
   localparam int LPC = 8;

   typedef logic [NL*W-1:0] vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sbox_lut_engine_if #(.NUM_LANES(NL), .SBOX_W(W)) bus ();

   sbox_lut_engine #(
      .NUM_LANES(NL), .SBOX_W(W), .LANES_PER_CYCLE(LPC)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   logic [4:0] asc [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };
   logic [4:0] tbl [32];

   vec_t exp_q [$];
   int   lat_q [$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   t_acc = 0;
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, vec_t act, vec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endfunction

   function automatic void chki(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endfunction

   function automatic void fail(string name);
      checks++;
      errors++;
      $display("FAIL %s: got timeout/unexpected want event", name);
   endfunction

   function automatic vec_t subst(vec_t d);
      vec_t r;
      for (int i = 0; i < NL; i++) r[i*W +: W] = tbl[d[i*W +: W]];
      return r;
   endfunction

   function automatic vec_t mk_mod();
      vec_t v;
      for (int i = 0; i < NL; i++) v[i*W +: W] = W'(i % 32);
      return v;
   endfunction

   function automatic vec_t mk_rev();
      vec_t v;
      for (int i = 0; i < NL; i++) v[i*W +: W] = W'(31 - (i % 32));
      return v;
   endfunction

   function automatic vec_t mk_fill(logic [W-1:0] x);
      vec_t v;
      for (int i = 0; i < NL; i++) v[i*W +: W] = x;
      return v;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (bus.in_valid_i && bus.in_ready_o) t_acc = cyc;
         if (bus.out_valid_o && !prev_v) begin
            if (lat_q.size() == 0) fail("unexpected_valid");
            else chki("latency", cyc - t_acc, lat_q.pop_front());
         end
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() == 0) fail("unexpected_output");
            else chk("out_data", bus.out_data_o, exp_q.pop_front());
         end
         prev_v = bus.out_valid_o;
      end
   end

   task automatic send(input vec_t d, input logic byp,
                       input bit push, input int lat);
      bit ok = 1'b0;
      bus.in_data_i   = d;
      bus.in_bypass_i = byp;
      bus.in_valid_i  = 1'b1;
      if (push) begin
         exp_q.push_back(byp ? d : subst(d));
         lat_q.push_back(lat);
      end
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.in_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) fail("accept_timeout");
      @(posedge clk); #1;
      bus.in_valid_i  = 1'b0;
      bus.in_bypass_i = 1'b0;
   endtask

   task automatic wr(input logic [W-1:0] a, input logic [W-1:0] d);
      bit ok = 1'b0;
      bus.cfg_wr_valid_i = 1'b1;
      bus.cfg_wr_addr_i  = a;
      bus.cfg_wr_data_i  = d;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.cfg_wr_ready_o) begin ok = 1'b1; break; end
      end
      if (!ok) fail("write_timeout");
      @(posedge clk); #1;
      bus.cfg_wr_valid_i = 1'b0;
      tbl[a] = d;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) fail("drain_timeout");
      @(posedge clk); #1;
   endtask

   task automatic wait_valid();
      bit ok = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.out_valid_o) begin ok = 1'b1; break; end
      end
      if (!ok) fail("valid_timeout");
   endtask

   initial begin
      vec_t snap;
      bus.cfg_wr_valid_i = 1'b0;
      bus.cfg_wr_addr_i  = '0;
      bus.cfg_wr_data_i  = '0;
      bus.in_valid_i     = 1'b0;
      bus.in_bypass_i    = 1'b0;
      bus.in_data_i      = '0;
      bus.out_ready_i    = 1'b1;
      for (int i = 0; i < 32; i++) tbl[i] = W'(i);

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chki("rst_in_ready", int'(bus.in_ready_o), 1);
      chki("rst_cfg_ready", int'(bus.cfg_wr_ready_o), 1);
      chki("rst_out_valid", int'(bus.out_valid_o), 0);
      chki("rst_busy", int'(bus.busy_o), 0);
      chk("rst_out_data", bus.out_data_o, '0);
      @(posedge clk); #1;

      // identity table after reset
      send(mk_mod(), 1'b0, 1'b1, 9);
      @(negedge clk);
      chki("busy_after_accept", int'(bus.busy_o), 1);
      drain();

      for (int i = 0; i < 32; i++) wr(W'(i), asc[i]);
      send(mk_mod(), 1'b0, 1'b1, 9);
      drain();

      // backpressure with ignored input pulses
      bus.out_ready_i = 1'b0;
      send(mk_rev(), 1'b0, 1'b1, 9);
      wait_valid();
      snap = bus.out_data_o;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         bus.in_valid_i = 1'b1;
         bus.in_data_i  = mk_fill(5'h03);
         @(negedge clk);
         chk("bp_stable", bus.out_data_o, snap);
         chki("bp_in_ready", int'(bus.in_ready_o), 0);
         chki("bp_valid", int'(bus.out_valid_o), 1);
      end
      @(posedge clk); #1;
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      @(negedge clk);
      chki("bp_consume_valid", int'(bus.out_valid_o), 1);
      @(negedge clk);
      chki("bp_idle_ready", int'(bus.in_ready_o), 1);
      chki("bp_idle_busy", int'(bus.busy_o), 0);
      @(posedge clk); #1;

      send(mk_fill(5'h1a), 1'b1, 1'b1, 1);
      drain();

      // write of entry 0 stalls while a vector is in flight
      send(mk_mod(), 1'b0, 1'b1, 9);
      bus.cfg_wr_valid_i = 1'b1;
      bus.cfg_wr_addr_i  = 5'h00;
      bus.cfg_wr_data_i  = 5'h00;
      @(negedge clk);
      chki("stall_busy_ready", int'(bus.cfg_wr_ready_o), 0);
      wait_valid();
      chki("stall_done_ready", int'(bus.cfg_wr_ready_o), 0);
      @(negedge clk);
      chki("stall_idle_ready", int'(bus.cfg_wr_ready_o), 1);
      @(posedge clk); #1;
      bus.cfg_wr_valid_i = 1'b0;
      tbl[0] = 5'h00;

      // write and accept in the same IDLE cycle
      bus.cfg_wr_valid_i = 1'b1;
      bus.cfg_wr_addr_i  = 5'h01;
      bus.cfg_wr_data_i  = 5'h1e;
      tbl[1] = 5'h1e;
      send(mk_mod(), 1'b0, 1'b1, 9);
      bus.cfg_wr_valid_i = 1'b0;
      drain();

      // reset on beat 3
      send(mk_mod(), 1'b0, 1'b0, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chki("mid_rst_valid", int'(bus.out_valid_o), 0);
      chki("mid_rst_in_ready", int'(bus.in_ready_o), 1);
      chk("mid_rst_data", bus.out_data_o, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) tbl[i] = W'(i);
      send(mk_mod(), 1'b0, 1'b1, 9);
      drain();

      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) fail("leftover_expected");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
